// File: rtl/dac_cfg_loader.sv
// Serial configuration loader: framed, addressed, even-parity words land in per-channel
// shadow registers, and a load strobe commits every shadow register to cfg_out at once.
module dac_cfg_loader #(
    parameter int NCH = 4,
    parameter int W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sdi,
    input  logic             sen,
    input  logic             load,
    input  logic             clr_err,
    output logic [NCH*W-1:0] cfg_out,
    output logic             busy,
    output logic             frame_ok,
    output logic             frm_err
);

    localparam int AW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int MAXF = (W > AW) ? W : AW;
    localparam int CW   = $clog2(MAXF) + 1;
    localparam logic [AW:0] NCH_LIM = (AW+1)'(NCH);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, PAR} state_t;

    state_t         state;
    logic [CW-1:0]  bit_cnt;
    logic [AW-1:0]  addr_sr;
    logic [W-1:0]   data_sr;
    logic [W-1:0]   shadow [NCH];
    logic           parity_ok;
    logic           addr_ok;

    // sdi carries the parity bit while in PAR, so the whole frame is checked on that edge
    assign parity_ok = ~(^{addr_sr, data_sr, sdi});
    assign addr_ok   = ({1'b0, addr_sr} < NCH_LIM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            addr_sr  <= '0;
            data_sr  <= '0;
            busy     <= 1'b0;
            frame_ok <= 1'b0;
            frm_err  <= 1'b0;
            for (int k = 0; k < NCH; k++) shadow[k] <= '0;
        end else begin
            frame_ok <= 1'b0;
            if (clr_err) frm_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (sen && sdi) begin
                        state   <= ADDR;
                        bit_cnt <= CW'(AW - 1);
                        busy    <= 1'b1;
                    end
                end
                ADDR: begin
                    if (!sen) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        busy    <= 1'b0;
                    end else begin
                        addr_sr <= AW'({addr_sr, sdi});
                        if (bit_cnt == '0) begin
                            state   <= DATA;
                            bit_cnt <= CW'(W - 1);
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (!sen) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        busy    <= 1'b0;
                    end else begin
                        data_sr <= W'({data_sr, sdi});
                        if (bit_cnt == '0) begin
                            state   <= PAR;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                PAR: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                    busy    <= 1'b0;
                    // an error set here overrides a clr_err seen on the same edge
                    if (sen) begin
                        if (parity_ok && addr_ok) begin
                            for (int k = 0; k < NCH; k++)
                                if (addr_sr == AW'(k)) shadow[k] <= data_sr;
                            frame_ok <= 1'b1;
                        end else begin
                            frm_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // cfg_out takes the pre-edge shadow contents, so a coinciding write needs a later load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_out <= '0;
        end else if (load) begin
            for (int k = 0; k < NCH; k++) cfg_out[k*W +: W] <= shadow[k];
        end
    end

endmodule

// File: tb/tb_dac_cfg_loader.sv
// Self-checking bench for dac_cfg_loader: a 4-channel and a 3-channel instance,
// with expected cfg_out values queued at load time and popped after the load edge.
module tb_dac_cfg_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sdi = 1'b0;
    logic        sen0 = 1'b0;
    logic        sen1 = 1'b0;
    logic        load = 1'b0;
    logic        clr_err = 1'b0;
    logic [31:0] cfg0;
    logic [23:0] cfg1;
    logic        busy0, frame_ok0, frm_err0;
    logic        busy1, frame_ok1, frm_err1;

    int total = 0;
    int bad   = 0;

    logic [7:0]  m0 [4];
    logic [7:0]  m1 [3];
    logic [31:0] exp_q [$];

    dac_cfg_loader #(.NCH(4), .W(8)) dut (
        .clk(clk), .rst(rst), .sdi(sdi), .sen(sen0), .load(load), .clr_err(clr_err),
        .cfg_out(cfg0), .busy(busy0), .frame_ok(frame_ok0), .frm_err(frm_err0)
    );

    dac_cfg_loader #(.NCH(3), .W(8)) dut3 (
        .clk(clk), .rst(rst), .sdi(sdi), .sen(sen1), .load(load), .clr_err(clr_err),
        .cfg_out(cfg1), .busy(busy1), .frame_ok(frame_ok1), .frm_err(frm_err1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pack_model(input int which);
        if (which == 0) return {m0[3], m0[2], m0[1], m0[0]};
        return {8'h00, m1[2], m1[1], m1[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sen(input int which, input logic v);
        if (which == 0) sen0 = v;
        else            sen1 = v;
    endtask

    task automatic clear_models();
        for (int k = 0; k < 4; k++) m0[k] = 8'h00;
        for (int k = 0; k < 3; k++) m1[k] = 8'h00;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        rst = 1'b0; sen0 = 1'b0; sen1 = 1'b0; sdi = 1'b0; load = 1'b0; clr_err = 1'b0;
        tick();
        clear_models();
        rst = 1'b1;
        tick();
    endtask

    // Drives one frame; stop_after>0 drops sen after that many bits.
    task automatic send_frame(input int which, input logic [1:0] addr, input logic [7:0] data,
                              input logic good_par, input int stop_after, input logic load_on_par);
        logic [11:0] bits;
        logic        p;
        p = ^{addr, data};
        if (!good_par) p = ~p;
        bits = {1'b1, addr, data, p};
        for (int i = 11; i >= 0; i--) begin
            if (stop_after > 0 && (11 - i) == stop_after) begin
                set_sen(which, 1'b0);
                sdi = 1'b0;
                tick();
                return;
            end
            sdi = bits[i];
            set_sen(which, 1'b1);
            load = (i == 0) ? load_on_par : 1'b0;
            if (i == 0 && load_on_par) exp_q.push_back(pack_model(which));
            tick();
            if (which == 0 && i == 11) begin
                total++;
                if (busy0 !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL busy_after_start: got %b expected 1", busy0);
                end
            end
        end
        set_sen(which, 1'b0);
        sdi  = 1'b0;
        load = 1'b0;
        if (good_par && ((which == 0) || (addr < 2'd3))) begin
            if (which == 0) m0[addr] = data;
            else            m1[addr] = data;
        end
    endtask

    task automatic do_load(input int which, input string name);
        logic [31:0] e;
        logic [31:0] got;
        load = 1'b1;
        exp_q.push_back(pack_model(which));
        tick();
        load = 1'b0;
        e   = exp_q.pop_front();
        got = (which == 0) ? cfg0 : {8'h00, cfg1};
        total++;
        if (got !== e) begin
            bad++;
            $display("[TB] FAIL %s: cfg_out got %h expected %h", name, got, e);
        end
    endtask

    task automatic test_reset();
        clear_models();
        #3;
        total++;
        if (cfg0 !== 32'h0) begin bad++; $display("[TB] FAIL reset_cfg: got %h expected 0", cfg0); end
        total++;
        if ({busy0, frame_ok0, frm_err0} !== 3'b000) begin
            bad++; $display("[TB] FAIL reset_flags: got %b expected 000", {busy0, frame_ok0, frm_err0});
        end
        total++;
        if (cfg1 !== 24'h0) begin bad++; $display("[TB] FAIL reset_cfg3: got %h expected 0", cfg1); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_accept();
        send_frame(0, 2'd2, 8'hA5, 1'b1, 0, 1'b0);
        total++;
        if (frame_ok0 !== 1'b1) begin bad++; $display("[TB] FAIL accept_frame_ok: got %b expected 1", frame_ok0); end
        total++;
        if (busy0 !== 1'b0) begin bad++; $display("[TB] FAIL accept_busy_low: got %b expected 0", busy0); end
        total++;
        if (cfg0 !== 32'h0) begin bad++; $display("[TB] FAIL accept_no_load: got %h expected 0", cfg0); end
        tick();
        total++;
        if (frame_ok0 !== 1'b0) begin bad++; $display("[TB] FAIL accept_pulse_width: got %b expected 0", frame_ok0); end
        do_load(0, "accept_load");
    endtask

    task automatic test_parity_err();
        apply_reset();
        send_frame(0, 2'd2, 8'hA5, 1'b0, 0, 1'b0);
        total++;
        if (frame_ok0 !== 1'b0) begin bad++; $display("[TB] FAIL parity_frame_ok: got %b expected 0", frame_ok0); end
        total++;
        if (frm_err0 !== 1'b1) begin bad++; $display("[TB] FAIL parity_err_set: got %b expected 1", frm_err0); end
        do_load(0, "parity_load");
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        total++;
        if (frm_err0 !== 1'b0) begin bad++; $display("[TB] FAIL parity_err_clear: got %b expected 0", frm_err0); end
        clr_err = 1'b1;
        send_frame(0, 2'd1, 8'h0F, 1'b0, 0, 1'b0);
        clr_err = 1'b0;
        total++;
        if (frm_err0 !== 1'b1) begin bad++; $display("[TB] FAIL set_beats_clear: got %b expected 1", frm_err0); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic test_abort();
        send_frame(0, 2'd1, 8'hC3, 1'b1, 5, 1'b0);
        total++;
        if (busy0 !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got %b expected 0", busy0); end
        send_frame(0, 2'd0, 8'h3C, 1'b1, 0, 1'b0);
        total++;
        if (frame_ok0 !== 1'b1) begin bad++; $display("[TB] FAIL abort_next_ok: got %b expected 1", frame_ok0); end
        do_load(0, "abort_load");
    endtask

    task automatic test_simul_load();
        logic [31:0] e;
        send_frame(0, 2'd1, 8'h11, 1'b1, 0, 1'b0);
        do_load(0, "simul_first_commit");
        send_frame(0, 2'd1, 8'h22, 1'b1, 0, 1'b1);
        e = exp_q.pop_front();
        total++;
        if (cfg0 !== e) begin bad++; $display("[TB] FAIL simul_old_value: cfg_out got %h expected %h", cfg0, e); end
        do_load(0, "simul_second_load");
    endtask

    task automatic test_reset_b2b();
        logic [11:0] bits;
        bits = {1'b1, 2'd1, 8'h55, ^{2'd1, 8'h55}};
        for (int i = 11; i >= 5; i--) begin
            sdi = bits[i];
            sen0 = 1'b1;
            tick();
        end
        #2;
        rst = 1'b0;
        #1;
        clear_models();
        total++;
        if ({cfg0, busy0, frame_ok0, frm_err0} !== 35'h0) begin
            bad++; $display("[TB] FAIL midframe_reset: got %h/%b expected 0", cfg0, {busy0, frame_ok0, frm_err0});
        end
        sen0 = 1'b0;
        sdi  = 1'b0;
        #2;
        rst = 1'b1;
        tick();
        send_frame(0, 2'd3, 8'hFF, 1'b1, 0, 1'b0);
        total++;
        if (frame_ok0 !== 1'b1) begin bad++; $display("[TB] FAIL b2b_first_ok: got %b expected 1", frame_ok0); end
        send_frame(0, 2'd0, 8'h01, 1'b1, 0, 1'b0);
        total++;
        if (frame_ok0 !== 1'b1) begin bad++; $display("[TB] FAIL b2b_second_ok: got %b expected 1", frame_ok0); end
        do_load(0, "b2b_load");
    endtask

    task automatic test_out_of_range();
        send_frame(1, 2'd2, 8'h77, 1'b1, 0, 1'b0);
        total++;
        if (frame_ok1 !== 1'b1) begin bad++; $display("[TB] FAIL nch3_valid_ok: got %b expected 1", frame_ok1); end
        send_frame(1, 2'd3, 8'h5A, 1'b1, 0, 1'b0);
        total++;
        if (frm_err1 !== 1'b1) begin bad++; $display("[TB] FAIL range_err: got %b expected 1", frm_err1); end
        total++;
        if (frame_ok1 !== 1'b0) begin bad++; $display("[TB] FAIL range_frame_ok: got %b expected 0", frame_ok1); end
        do_load(1, "range_load");
    endtask

    initial begin
        $display("[TB] starting dac_cfg_loader bench");
        test_reset();
        test_accept();
        test_parity_err();
        test_abort();
        test_simul_load();
        test_reset_b2b();
        test_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dac_cfg_loader.md
# dac_cfg_loader

Parametrised serial configuration loader for the DAC control path. It receives framed, addressed, parity-protected words on one serial line and writes each into a per-channel shadow register. A `load` strobe commits all shadow registers to the active outputs at once. It replaces fixed-width, single-field shift registers with one shared NCH-channel, W-bit interface that adds framing, error detection and double buffering.

## Interface
- `NCH`, default 4: number of configuration channels; must be at least 2.
- `W`, default 8: data width of each channel.
- `AW`, default $clog2(NCH): address field width. It is derived, not overridden.
- `clk`  input  1  sole clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous and active-low.
- `sdi`  input  1  serial data, sampled on every rising edge of `clk`.
- `sen`  input  1  serial enable. Low at any point in a frame aborts the frame.
- `load`  input  1  commit strobe, level-sampled: copies shadow to active.
- `clr_err`  input  1  clears `frm_err`.
- `cfg_out`  output  NCH*W  active registers. Channel k occupies bits [k*W+W-1 : k*W].
- `busy`  output  1  a frame is in progress.
- `frame_ok`  output  1  one-cycle pulse when a frame is accepted.
- `frm_err`  output  1  sticky error flag: parity error or out-of-range address.

## Operation
- **Frame format**, all fields MSB-first on `sdi`, one bit per cycle with `sen`=1:
  - one start bit, always 1;
  - AW address bits;
  - W data bits;
  - one even-parity bit P, where XOR(addr, data, P) = 0.
- **Frame length:** 2+AW+W cycles.
- **State machine:** IDLE, ADDR, DATA, PAR. A bit counter is reloaded on every state entry.
- **IDLE:** go to ADDR when `sen`=1 and `sdi`=1. Otherwise stay in IDLE; a 0 on `sdi` is treated as line idle.
- **ADDR:** shift AW bits, then go to DATA.
- **DATA:** shift W bits, then go to PAR.
- **PAR:** sample P, then return to IDLE.
- **Frame check on the PAR edge:**
  - Accepted when parity is good and addr < NCH: `shadow[addr]` <= data, and `frame_ok` is high for the next cycle.
  - Rejected when parity is bad or addr >= NCH: shadow is unchanged and `frm_err` is set.
- **Abort:** `sen`=0 in ADDR, DATA or PAR returns the FSM to IDLE at that edge. There is no write and no error.
- **Load:** on any edge with `load`=1, all NCH active registers take the shadow values as they were before that edge.
- **Error flag:** `clr_err`=1 clears `frm_err`. If a set and a clear happen on the same edge, the set wins.
- **Reset** (`rst`=0, asynchronous):
  - FSM goes to IDLE and the counter clears.
  - All shadow registers and `cfg_out` go to 0.
  - `busy`, `frame_ok` and `frm_err` go to 0.
  - Reset mid-frame discards the partial frame.

## Timing
- **`busy`:** registered. It goes high in the cycle after the start bit is sampled and stays high through the cycle in which P is sampled. It goes low in the cycle after that.
- **`frame_ok`:** registered. It is high for exactly the one cycle after the PAR edge.
- **Back-to-back frames:** a new start bit is accepted on the edge immediately after the PAR edge, so frames need no gap.
- **Write-to-active latency:**
  - A shadow write becomes visible on `cfg_out` one edge after the first `load` that follows the write edge.
  - When `load` and an accepting PAR edge coincide, `cfg_out` gets the old shadow value. The new data needs a later `load`.
- **`cfg_out`:** changes only on `load` edges or reset. It is glitch-free because it is driven directly from flops.
- **`sen` vs start bit:** `sen` is checked on the start-bit edge as well. `sen`=0 together with `sdi`=1 in IDLE is ignored.

## Test plan
- **Accepted write + load** (NCH=4, W=8, defaults):
  - Stimulus: frame addr=2, data=0xA5, P=1, sent as bits 1,1,0,1,0,1,0,0,1,0,1,1; then pulse `load`.
  - Required: `frame_ok` pulses once. `cfg_out`[23:16]=0xA5 after `load`; all other bytes stay 0x00.
- **Parity error:**
  - Stimulus: the same frame with P=0.
  - Required: no `frame_ok`; `frm_err`=1. After `load`, `cfg_out`=0. `clr_err` returns `frm_err` to 0.
- **Abort:**
  - Stimulus: drop `sen` after 5 frame bits, then send a full valid frame addr=0, data=0x3C.
  - Required: `busy` falls the cycle after `sen` drops, with no write. The second frame is accepted, and after `load` `cfg_out`[7:0]=0x3C.
- **Simultaneous load:**
  - Stimulus: `shadow[1]`=0x11 already committed; then a frame addr=1, data=0x22 with `load`=1 on its PAR edge, then another `load`.
  - Required: `cfg_out`[15:8]=0x11 after the first `load` edge and 0x22 after the second.
- **Reset mid-frame and back-to-back frames:**
  - Stimulus: assert `rst` low during DATA; then, with no idle gap, send frames addr=3/0xFF then addr=0/0x01, then `load`.
  - Required: everything reads 0 after reset. Both frames are accepted with two `frame_ok` pulses. `cfg_out` = 0xFF0000_01 (byte3=0xFF, byte0=0x01).
- **Out-of-range address:**
  - Stimulus: NCH=3, W=8 build; frame addr=3 with correct parity.
  - Required: `frm_err`=1, no shadow change.
